// File: rtl/noc_out_arbiter_if.sv
// Input-side bus of the NoC output-port arbiter: per-port flit requests,
// packet framing flags, flit data and the one-hot grant back to the requesters.
interface noc_out_arbiter_if #(
    parameter int N_IN  = 5,
    parameter int WIDTH = 34
);
    logic [N_IN-1:0]       req_i;
    logic [N_IN-1:0]       head_i;
    logic [N_IN-1:0]       tail_i;
    logic [N_IN*WIDTH-1:0] data_i;
    logic [N_IN-1:0]       gnt_o;

    // Requesters drive flits and observe the grant.
    modport master (output req_i, head_i, tail_i, data_i, input gnt_o);

    // The arbiter observes flits and drives the grant.
    modport slave (input req_i, head_i, tail_i, data_i, output gnt_o);
endinterface

// File: rtl/noc_out_arbiter.sv
// Output-port controller for one NoC router port.
// Shares a single downstream flit queue among N_IN input ports with packet-level
// round-robin arbitration: the grant is locked from head flit to tail flit.
// A credit counter mirrors free queue slots so the queue never overflows.
// Optional build macro: NOC_ARB_ERR_CHECK_EN adds a sticky err_o output that
// flags credit overflow and nested head flits inside a locked packet.
module noc_out_arbiter #(
    parameter int N_IN  = 5,
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    noc_out_arbiter_if.slave in_if,
    input  logic             credit_i,
    output logic             write_en_o,
    output logic [WIDTH-1:0] write_data_o,
    output logic [CW-1:0]    credits_o,
    output logic             busy_o
`ifdef NOC_ARB_ERR_CHECK_EN
    ,
    output logic             err_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             write_en_q, write_en_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;

    logic [N_IN-1:0]  eligible;
    logic [N_IN-1:0]  gnt_raw;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    gnt_idx;
    logic             found;
    logic             grant;
    logic             has_credit;
    logic [WIDTH-1:0] port_data [N_IN];

    // Advance a round-robin pointer, wrapping at the last port.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == N_IN - 1) ? '0 : p + 1'b1;
    endfunction

    for (genvar k = 0; k < N_IN; k++) begin : g_unpack
        assign port_data[k] = in_if.data_i[k*WIDTH +: WIDTH];
    end

    assign eligible   = in_if.req_i & in_if.head_i;
    assign has_credit = (credits_q != '0);

    // Find the first eligible port searching upward from rr_ptr with wrap-around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N_IN; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % N_IN);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant decision, next-state, credit bookkeeping and write-port staging.
    always_comb begin
        grant        = 1'b0;
        gnt_idx      = winner;
        gnt_raw      = '0;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        credits_d    = credits_q;
        write_en_d   = 1'b0;
        write_data_d = write_data_q;

        if (state_q == IDLE) begin
            if (found && has_credit) begin
                grant   = 1'b1;
                gnt_idx = winner;
                if (in_if.tail_i[winner]) begin
                    rr_ptr_d = next_ptr(winner);
                end else begin
                    owner_d = winner;
                    state_d = LOCKED;
                end
            end
        end else begin
            if (in_if.req_i[owner_q] && has_credit) begin
                grant   = 1'b1;
                gnt_idx = owner_q;
                if (in_if.tail_i[owner_q]) begin
                    rr_ptr_d = next_ptr(owner_q);
                    state_d  = IDLE;
                end
            end
        end

        gnt_raw[gnt_idx] = grant;

        if (grant) begin
            write_en_d   = 1'b1;
            write_data_d = port_data[gnt_idx];
        end

        if (grant && !credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!grant && credit_i && (credits_q < CW'(DEPTH))) begin
            credits_d = credits_q + 1'b1;
        end
    end

    // Hold the grant low while reset is asserted so nothing is popped.
    assign in_if.gnt_o = rst ? gnt_raw : '0;

    // Arbiter state, credit counter and registered queue write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            credits_q    <= CW'(DEPTH);
            write_en_q   <= 1'b0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            credits_q    <= credits_d;
            write_en_q   <= write_en_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en_o   = write_en_q;
    assign write_data_o = write_data_q;
    assign credits_o    = credits_q;
    assign busy_o       = (state_q == LOCKED);

`ifdef NOC_ARB_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky error: credit returned with the counter already full, or a head flit inside a packet.
    always_comb begin
        err_d = err_q
              | (credit_i && !grant && (credits_q == CW'(DEPTH)))
              | ((state_q == LOCKED) && grant && in_if.head_i[owner_q]);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter: a per-cycle vector table covering
// round-robin, packet lock, credit handling and non-head requests, plus
// hand-written sequences for credit exhaustion and reset mid-packet.
module tb_noc_out_arbiter;

    localparam int N_IN  = 5;
    localparam int WIDTH = 34;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NVEC  = 20;

    logic             clk;
    logic             rst;
    logic             credit_i;
    logic             write_en_o;
    logic [WIDTH-1:0] write_data_o;
    logic [CW-1:0]    credits_o;
    logic             busy_o;
`ifdef NOC_ARB_ERR_CHECK_EN
    logic             err_o;
`endif

    int compared;
    int mismatched;

    noc_out_arbiter_if #(.N_IN(N_IN), .WIDTH(WIDTH)) bus ();

    noc_out_arbiter #(.N_IN(N_IN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (bus.slave),
        .credit_i     (credit_i),
        .write_en_o   (write_en_o),
        .write_data_o (write_data_o),
        .credits_o    (credits_o),
        .busy_o       (busy_o)
`ifdef NOC_ARB_ERR_CHECK_EN
        ,
        .err_o        (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  req;
        logic [4:0]  head;
        logic [4:0]  tail;
        logic        credit;
        logic [4:0]  exp_gnt;
        logic        exp_we;
        logic [33:0] exp_wd;
        logic [2:0]  exp_cr;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [4:0] req, input logic [4:0] head,
                                input logic [4:0] tail, input logic credit,
                                input logic [4:0] gnt, input logic we,
                                input logic [33:0] wd, input logic [2:0] cr,
                                input logic busy);
        vec_t v;
        v.req = req; v.head = head; v.tail = tail; v.credit = credit;
        v.exp_gnt = gnt; v.exp_we = we; v.exp_wd = wd; v.exp_cr = cr;
        v.exp_busy = busy;
        return v;
    endfunction

    // Flit of port k under tag t is 0x100 + 16*t + k, so every write is traceable.
    function automatic logic [WIDTH-1:0] flit(input int t, input int k);
        return WIDTH'(32'h100 + t * 16 + k);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, leave 1 time unit to settle.
    task automatic applyStimulus(input logic [4:0] req, input logic [4:0] head,
                                 input logic [4:0] tail, input logic credit, input int tag);
        @(negedge clk);
        bus.req_i  = req;
        bus.head_i = head;
        bus.tail_i = tail;
        credit_i   = credit;
        for (int k = 0; k < N_IN; k++) bus.data_i[k*WIDTH +: WIDTH] = flit(tag, k);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        bus.req_i  = '0;
        bus.head_i = '0;
        bus.tail_i = '0;
        bus.data_i = '0;
        credit_i   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst credits", 64'(credits_o), 64'(DEPTH));
        checkOutput("rst we", 64'(write_en_o), 64'd0);
        checkOutput("rst wd", 64'(write_data_o), 64'd0);
        checkOutput("rst busy", 64'(busy_o), 64'd0);
`ifdef NOC_ARB_ERR_CHECK_EN
        checkOutput("rst err", 64'(err_o), 64'd0);
`endif
        rst = 1'b1;
    endtask

    initial begin
        int grants;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        credit_i   = 1'b0;
        bus.req_i  = '0;
        bus.head_i = '0;
        bus.tail_i = '0;
        bus.data_i = '0;

        //             req       head      tail      cr    gnt       we    wd         cr    busy
        // round robin among ports 0,2,4 with single-flit packets and a credit every cycle
        vecs[0]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00001, 1'b0, 34'h000, 3'd4, 1'b0);
        vecs[1]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00100, 1'b1, 34'h100, 3'd4, 1'b0);
        vecs[2]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b10000, 1'b1, 34'h112, 3'd4, 1'b0);
        vecs[3]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00001, 1'b1, 34'h124, 3'd4, 1'b0);
        vecs[4]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00100, 1'b1, 34'h130, 3'd4, 1'b0);
        vecs[5]  = mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b10000, 1'b1, 34'h142, 3'd4, 1'b0);
        // port 1 three-flit packet locks out port 3's head; port 3 follows
        vecs[6]  = mk(5'b01010, 5'b01010, 5'b00000, 1'b0, 5'b00010, 1'b1, 34'h154, 3'd4, 1'b0);
        vecs[7]  = mk(5'b01010, 5'b01000, 5'b00000, 1'b0, 5'b00010, 1'b1, 34'h161, 3'd3, 1'b1);
        vecs[8]  = mk(5'b01010, 5'b01000, 5'b00010, 1'b0, 5'b00010, 1'b1, 34'h171, 3'd2, 1'b1);
        vecs[9]  = mk(5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b01000, 1'b1, 34'h181, 3'd1, 1'b0);
        // credits exhausted, then one credit lets one flit through
        vecs[10] = mk(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00000, 1'b1, 34'h193, 3'd0, 1'b0);
        vecs[11] = mk(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00000, 1'b0, 34'h193, 3'd0, 1'b0);
        vecs[12] = mk(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b0, 34'h193, 3'd1, 1'b0);
        // port 2 request without head is ignored, then its head is granted with a credit in the same cycle
        vecs[13] = mk(5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 34'h1C0, 3'd0, 1'b0);
        vecs[14] = mk(5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 34'h1C0, 3'd1, 1'b0);
        vecs[15] = mk(5'b00100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b0, 34'h1C0, 3'd2, 1'b0);
        // refill to DEPTH and saturate
        vecs[16] = mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 34'h1F2, 3'd2, 1'b0);
        vecs[17] = mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 34'h1F2, 3'd3, 1'b0);
        vecs[18] = mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 34'h1F2, 3'd4, 1'b0);
        vecs[19] = mk(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 34'h1F2, 3'd4, 1'b0);

        $display("[TB] reset and vector table");
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].req, vecs[i].head, vecs[i].tail, vecs[i].credit, i);
            checkOutput($sformatf("v%0d gnt", i), 64'(bus.gnt_o), 64'(vecs[i].exp_gnt));
            checkOutput($sformatf("v%0d we", i), 64'(write_en_o), 64'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d wd", i), 64'(write_data_o), 64'(vecs[i].exp_wd));
            checkOutput($sformatf("v%0d credits", i), 64'(credits_o), 64'(vecs[i].exp_cr));
            checkOutput($sformatf("v%0d busy", i), 64'(busy_o), 64'(vecs[i].exp_busy));
        end
`ifdef NOC_ARB_ERR_CHECK_EN
        checkOutput("err after overflow", 64'(err_o), 64'd1);
`endif

        $display("[TB] credit exhaustion on a 6-flit packet");
        do_reset();
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(5'b00001, (c == 0) ? 5'b00001 : 5'b00000, 5'b00000, 1'b0, 40 + c);
            if (bus.gnt_o[0]) grants++;
        end
        checkOutput("exhaust grants", 64'(grants), 64'd4);
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b1, 50);
        checkOutput("exhaust credits", 64'(credits_o), 64'd0);
        checkOutput("exhaust gnt", 64'(bus.gnt_o), 64'd0);
        checkOutput("exhaust busy", 64'(busy_o), 64'd1);
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0, 51 + c);
            if (bus.gnt_o[0]) grants++;
        end
        checkOutput("one credit one grant", 64'(grants), 64'd1);

        $display("[TB] reset mid-packet");
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b1, 60);
        checkOutput("pre-rst gnt", 64'(bus.gnt_o), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid rst gnt", 64'(bus.gnt_o), 64'd0);
        checkOutput("mid rst we", 64'(write_en_o), 64'd0);
        checkOutput("mid rst wd", 64'(write_data_o), 64'd0);
        checkOutput("mid rst credits", 64'(credits_o), 64'(DEPTH));
        checkOutput("mid rst busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0, 61);
        checkOutput("post rst body ignored", 64'(bus.gnt_o), 64'd0);
        applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b0, 62);
        checkOutput("post rst head gnt", 64'(bus.gnt_o), 64'd1);
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b0, 63);
        checkOutput("post rst we", 64'(write_en_o), 64'd1);
        checkOutput("post rst wd", 64'(write_data_o), 64'(flit(62, 0)));
        checkOutput("post rst credits", 64'(credits_o), 64'd3);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Output-port controller for one NoC router port: shares a single downstream flit queue (the WIDTH-wide FF/queue datapath) among N_IN input ports.
- Arbitrates round-robin at packet granularity and locks the grant from head flit to tail flit.
- Drives the queue's write enable and write data, and tracks downstream space with a credit counter so the queue never overflows.

Parameters:
- N_IN, 5, number of requesting input ports (N_IN >= 2).
- WIDTH, 34, flit width in bits; matches the downstream queue's WIDTH.
- DEPTH, 4, downstream queue depth; this is the initial credit count (DEPTH >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_i  input  N_IN  per-port flit-valid request.
- head_i  input  N_IN  per-port flag: the presented flit is a packet head.
- tail_i  input  N_IN  per-port flag: the presented flit is a packet tail (head and tail both set = single-flit packet).
- data_i  input  N_IN*WIDTH  per-port flit; port k occupies bits [k*WIDTH +: WIDTH].
- gnt_o  input-side acknowledge, output  N_IN  one-hot, combinational; the requester pops its flit in the cycle gnt_o[k]=1.
- credit_i  input  1  downstream queue freed one slot this cycle.
- write_en_o  output  1  registered queue write enable.
- write_data_o  output  WIDTH  registered queue write data.
- credits_o  output  $clog2(DEPTH+1)  current credit count.
- busy_o  output  1  high while in LOCKED.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, credits=DEPTH.
  - write_en_o=0, write_data_o=0, busy_o=0, gnt_o=0.
  - An in-flight packet is abandoned; no flit is written after reset asserts.
- gnt_o is never asserted when credits==0. At most one bit of gnt_o is set in any cycle.
- IDLE state:
  - Eligible ports are those with req_i[k] & head_i[k]. A request without head_i is ignored (no grant).
  - If credits>0 and at least one port is eligible, grant the first eligible port searching from rr_ptr upward, wrapping modulo N_IN.
  - Granted flit is head+tail: stay in IDLE and set rr_ptr = (winner+1) mod N_IN.
  - Otherwise: owner=winner, go to LOCKED.
- LOCKED state:
  - Only owner can be granted. gnt_o[owner] = req_i[owner] & (credits>0). All other requests are ignored, even those with head_i set.
  - Stalls (req_i[owner]=0 or credits==0) hold the state indefinitely.
  - A grant with tail_i[owner]=1 returns to IDLE and sets rr_ptr = (owner+1) mod N_IN.
- rr_ptr changes only at packet completion, never on head grants.
- Datapath:
  - On a grant, the next cycle has write_en_o=1 and write_data_o = the granted flit (latency 1).
  - With no grant, write_en_o=0 and write_data_o holds its last value.
  - Back-to-back grants give back-to-back writes.
- Credits:
  - Grant only: decrement by 1.
  - credit_i only: increment by 1.
  - Grant and credit_i in the same cycle: unchanged.
  - credit_i when credits==DEPTH and no grant: saturate at DEPTH (ignored).
  - credits never underflows, because a grant requires credits>0.
- busy_o = (state==LOCKED).

Optional Feature:
- Macro: NOC_ARB_ERR_CHECK_EN.
- When defined, the block adds output err_o (1 bit, sticky, cleared only by reset). err_o sets on the next edge after either condition:
  - credit_i arrives while credits==DEPTH and there is no grant (credit overflow).
  - The owner's granted flit in LOCKED has head_i=1 (nested head).
- When undefined, err_o does not exist and both conditions are silently tolerated as described in Behaviour.

Test Plan:
- Reset: after reset with DEPTH=4 -> credits_o=4, write_en_o=0, write_data_o=0, busy_o=0; assert rst low mid-packet -> outputs clear immediately and state returns to IDLE.
- Round-robin fairness: ports 0, 2 and 4 each continuously send single-flit packets, with credit_i returned every cycle -> grants in order 0, 2, 4, 0, 2, 4; each write_data_o equals the granted port's data one cycle later.
- Packet lock: port 1 sends a 3-flit packet (head, body, tail) while port 3 requests a head -> gnt_o=0b00010 for 3 grant cycles, then port 3 is granted; busy_o is high from the cycle after port 1's head through port 1's tail cycle.
- Credit exhaustion: DEPTH=4, no credit_i, port 0 sends a 6-flit packet -> 4 grants, then credits_o=0 and gnt_o=0; one credit_i pulse -> exactly one more grant occurs.
- Simultaneous grant and credit_i with credits=2 -> credits_o stays 2; credit_i at credits=4 with no grant -> credits_o stays 4 (and err_o=1 when NOC_ARB_ERR_CHECK_EN is defined).
- Non-head request in IDLE: port 2 asserts req_i=1 with head_i=0 -> no grant and no write; a subsequent head from port 2 is then granted normally.
